pwm_deadtime: RTL
=================

Name: pwm_deadtime

Overview:
- Downstream stage of the PI controller: converts the controller's signed 32-bit command into a switching period for the resonant converter's half-bridge.
- Generates two complementary gate signals with fixed dead time, plus a period-start strobe.
- The commanded period is clamped to safe limits.
- The new period is applied only at a period boundary, so the bridge never sees a truncated or glitched half-cycle.

Parameters:
- N_BIT, 32, width of the period command (matches PI output width)
- PERIOD_MIN, 50, minimum period in i_CLK cycles; must satisfy PERIOD_MIN >= 2*DEADTIME+2
- PERIOD_MAX, 1000, maximum period in i_CLK cycles
- DEADTIME, 10, number of cycles both gates are low before each gate turns on

Ports:
- i_CLK  input  1  system clock
- i_RST  input  1  asynchronous, active-low reset
- i_EN  input  1  modulator enable, sampled on posedge i_CLK
- i_period  input  N_BIT signed  commanded period in clock cycles (PI output)
- o_Q_H  output  1  high-side gate, registered
- o_Q_L  output  1  low-side gate, registered
- o_SYNC  output  1  one-cycle pulse in cycle 0 of every period
- o_period  output  N_BIT  clamped period currently in use

Behaviour:
- Reset: i_RST low forces the following immediately, regardless of clock:
  - o_Q_H=0, o_Q_L=0, o_SYNC=0, o_period=0
  - internal counter cleared; state IDLE
- States:
  - IDLE: all outputs 0.
  - RUN: counter c runs 0..P-1 and wraps.
- IDLE->RUN: i_EN=1 sampled at edge k.
  - The cycle after edge k is cycle 0 of the first period.
  - P = clamp(i_period sampled at edge k); o_period=P and o_SYNC=1 in that cycle.
- RUN->IDLE: i_EN=0 sampled at any edge.
  - All gates and o_SYNC are 0 from the next cycle.
  - Counter cleared; o_period holds its last value.
  - No completion of the current period.
- Clamp rule, signed compare:
  - i_period < PERIOD_MIN -> PERIOD_MIN (includes negative values)
  - i_period > PERIOD_MAX -> PERIOD_MAX
  - otherwise passed through unchanged.
- Period update:
  - i_period is sampled only at the edge that starts a new period (c wraps P-1 -> 0).
  - Changes within a period have no effect until the next boundary.
- Waveform within one period, H = floor(P/2), cycle indices counted from the o_SYNC cycle:
  - cycles 0..DEADTIME-1: both gates 0
  - cycles DEADTIME..H-1: o_Q_H=1
  - cycles H..H+DEADTIME-1: both gates 0
  - cycles H+DEADTIME..P-1: o_Q_L=1
- Odd P: the low-side phase gets the extra cycle.
- o_Q_H and o_Q_L are never 1 in the same cycle, under any input sequence, including reset and enable toggling.
- All outputs are driven from flops: no combinational path from inputs to outputs.
- Counter width: N_BIT bits is sufficient; no wrap-around other than P-1 -> 0.

Test Plan:
- Period 100, i_EN=1 after reset (defaults) -> o_SYNC every 100 cycles; o_Q_H high cycles 10..49 (40 cycles); o_Q_L high cycles 60..99; o_period=100.
- i_period 100 -> 200 changed at cycle 30 of a period -> current period still 100 cycles; next o_SYNC begins a 200-cycle period with o_Q_H 10..99 and o_Q_L 110..199.
- i_period = -5, then 5000, then 101 -> o_period = 50, then 1000, then 101. The 50-cycle period has o_Q_H 10..24 and o_Q_L 35..49. The 101-cycle period has o_Q_H 10..49 and o_Q_L 60..100.
- i_EN deasserted while o_Q_H=1 -> next cycle o_Q_H=o_Q_L=o_SYNC=0. Re-enable -> fresh period starts with o_SYNC and a full 10-cycle dead time.
- i_RST pulsed low mid-period, between clock edges -> outputs 0 immediately. After release with i_EN=1, waveform restarts at cycle 0 with freshly sampled period.
- Random i_period and random i_EN toggling for 1e5 cycles -> assertion that o_Q_H and o_Q_L are never both 1. Every o_Q rising edge is preceded by at least DEADTIME cycles with both gates 0.

Source files
------------

// File: rtl/pwm_deadtime.sv
// Complementary half-bridge PWM with fixed dead time and a clamped period command.
// The period is latched only at a period boundary so a half-cycle is never truncated.
module pwm_deadtime #(
    parameter int N_BIT      = 32,
    parameter int PERIOD_MIN = 50,
    parameter int PERIOD_MAX = 1000,
    parameter int DEADTIME   = 10
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_EN,
    input  logic signed [N_BIT-1:0] i_period,
    output logic                    o_Q_H,
    output logic                    o_Q_L,
    output logic                    o_SYNC,
    output logic        [N_BIT-1:0] o_period
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic signed [N_BIT-1:0] P_MIN = N_BIT'(PERIOD_MIN);
    localparam logic signed [N_BIT-1:0] P_MAX = N_BIT'(PERIOD_MAX);
    localparam logic        [N_BIT-1:0] DT    = N_BIT'(DEADTIME);
    localparam logic        [N_BIT-1:0] ONE   = N_BIT'(1);

    // Signed compare so negative PI commands fall to the minimum period.
    function automatic logic [N_BIT-1:0] clamp_period(input logic signed [N_BIT-1:0] cmd);
        logic [N_BIT-1:0] res;
        if (cmd < P_MIN) begin
            res = P_MIN;
        end else if (cmd > P_MAX) begin
            res = P_MAX;
        end else begin
            res = cmd;
        end
        return res;
    endfunction

    state_t           state_r, state_s;
    logic [N_BIT-1:0] cnt_r, cnt_s;
    logic [N_BIT-1:0] period_r, period_s;
    logic [N_BIT-1:0] half_s;
    logic             q_h_r, q_h_s;
    logic             q_l_r, q_l_s;
    logic             sync_r, sync_s;

    // Next state, next counter and the period latched at each boundary.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        period_s = period_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                if (i_EN) begin
                    state_s  = ST_RUN;
                    period_s = clamp_period(i_period);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!i_EN) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else if (cnt_r == period_r - ONE) begin
                    cnt_s    = '0;
                    period_s = clamp_period(i_period);
                end else begin
                    cnt_s = cnt_r + ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Gate pattern decoded from the next counter value so the outputs can be flopped.
    always_comb begin
        half_s = period_s >> 1;
        sync_s = 1'b0;
        q_h_s  = 1'b0;
        q_l_s  = 1'b0;
        if (state_s == ST_RUN) begin
            sync_s = (cnt_s == '0);
            q_h_s  = (cnt_s >= DT) && (cnt_s < half_s);
            q_l_s  = (cnt_s >= half_s + DT) && (cnt_s < period_s);
        end else begin
            sync_s = 1'b0;
            q_h_s  = 1'b0;
            q_l_s  = 1'b0;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            period_r <= '0;
            q_h_r    <= 1'b0;
            q_l_r    <= 1'b0;
            sync_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            period_r <= period_s;
            q_h_r    <= q_h_s;
            q_l_r    <= q_l_s;
            sync_r   <= sync_s;
        end
    end

    assign o_Q_H    = q_h_r;
    assign o_Q_L    = q_l_r;
    assign o_SYNC   = sync_r;
    assign o_period = period_r;

endmodule
